// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter.
//   slot_e     : owner of the single RAM operation in a given cycle
//   cpu_st_e   : CPU-port handshake state
//   wr_entry_t : one posted CPU write (address + data)
// The entry layout uses VRAM_AW/VRAM_DW; the arbiter's AW/DW default to these.
package vram_arb_pkg;

   localparam int unsigned VRAM_AW = 15;
   localparam int unsigned VRAM_DW = 8;

   typedef enum logic [2:0] {
      SLOT_IDLE,
      SLOT_VID,
      SLOT_LD,
      SLOT_WR,
      SLOT_RD
   } slot_e;

   typedef enum logic [1:0] {
      C_IDLE,
      C_WACK,
      C_RWAIT,
      C_RDATA
   } cpu_st_e;

   typedef struct packed {
      logic [VRAM_AW-1:0] addr;
      logic [VRAM_DW-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/vram_wfifo.sv
// Posted-write FIFO for the CPU port.
//   clk_sys, reset : clock, synchronous active-high reset (flushes contents)
//   push_i/wdata_i : enqueue one entry (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : current head entry
//   full_o/empty_o : occupancy flags
// Pointers carry one extra wrap bit so full/empty fall out of a plain compare.
module vram_wfifo
   import vram_arb_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic      clk_sys,
   input  logic      reset,
   input  logic      push_i,
   input  logic      pop_i,
   input  wr_entry_t wdata_i,
   output wr_entry_t head_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned IdxW = $clog2(Depth);

   logic [IdxW:0] wptr_q, rptr_q;
   wr_entry_t     mem_q [Depth];
   logic          do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[IdxW] != rptr_q[IdxW]) &&
                    (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rptr_q[IdxW-1:0]];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk_sys) begin
      if (do_push) mem_q[wptr_q[IdxW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/vram_arbiter.sv
// Time-shares the single-port VRAM between video fetch, the loader and the CPU.
//   Video  : vid_req/vid_addr -> vid_dout/vid_valid, always wins, 1-cycle latency
//   Loader : ld_wr/ld_addr/ld_din into a one-entry holding register, ld_ready
//   CPU    : cpu_req/cpu_we/cpu_addr/cpu_din -> cpu_dout/cpu_ack, posted writes,
//            blocking reads ordered behind all queued writes
//   RAM    : ram_addr/ram_din/ram_we out, ram_dout in (registered, 1-cycle)
// Optional build macro VRAM_ARBITER_STATS_EN adds stat_cpu_stall and
// stat_fifo_full saturating counters.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int unsigned AW          = VRAM_AW,
   parameter int unsigned DW          = VRAM_DW,
   parameter int unsigned WFIFO_DEPTH = 4
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_dout,
   output logic          vid_valid,
   input  logic          ld_wr,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_din,
   output logic          ld_ready,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic [DW-1:0] cpu_dout,
   output logic          cpu_ack,
`ifdef VRAM_ARBITER_STATS_EN
   output logic [15:0]   stat_cpu_stall,
   output logic [15:0]   stat_fifo_full,
`endif
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout
);

   cpu_st_e       st_q, st_d;
   slot_e         slot;
   logic          ld_full_q;
   logic [AW-1:0] ld_addr_q;
   logic [DW-1:0] ld_data_q;
   logic          vid_valid_q;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   wr_entry_t     fifo_wdata, fifo_head;

   assign fifo_wdata = '{addr: cpu_addr, data: cpu_din};
   assign fifo_pop   = (slot == SLOT_WR);

   vram_wfifo #(
      .Depth(WFIFO_DEPTH)
   ) u_wfifo (
      .clk_sys (clk_sys),
      .reset   (reset),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (fifo_wdata),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Slot winner. A read only reaches its slot once the FIFO is empty, which
   // is what keeps CPU reads ordered behind its own posted writes.
   always_comb begin
      slot = SLOT_IDLE;
      if (vid_req)                slot = SLOT_VID;
      else if (ld_full_q)         slot = SLOT_LD;
      else if (!fifo_empty)       slot = SLOT_WR;
      else if (st_q == C_RWAIT)   slot = SLOT_RD;
   end

   always_comb begin
      ram_we   = 1'b0;
      ram_addr = vid_addr;
      ram_din  = '0;
      unique case (slot)
         SLOT_LD: begin
            ram_we   = 1'b1;
            ram_addr = ld_addr_q;
            ram_din  = ld_data_q;
         end
         SLOT_WR: begin
            ram_we   = 1'b1;
            ram_addr = fifo_head.addr;
            ram_din  = fifo_head.data;
         end
         SLOT_RD: ram_addr = cpu_addr;
         default: ;
      endcase
      if (reset) begin
         ram_we   = 1'b0;
         ram_addr = '0;
         ram_din  = '0;
      end
   end

   // CPU handshake. Requests are only looked at in C_IDLE, so a request still
   // held high during its ack cycle is not served twice.
   always_comb begin
      st_d      = st_q;
      fifo_push = 1'b0;
      cpu_ack   = 1'b0;
      unique case (st_q)
         C_IDLE: begin
            if (cpu_req) begin
               if (!cpu_we) begin
                  st_d = C_RWAIT;
               end else if (!fifo_full) begin
                  fifo_push = 1'b1;
                  st_d      = C_WACK;
               end
            end
         end
         C_WACK: begin
            cpu_ack = 1'b1;
            st_d    = C_IDLE;
         end
         C_RWAIT: begin
            if (slot == SLOT_RD) st_d = C_RDATA;
         end
         C_RDATA: begin
            cpu_ack = 1'b1;
            st_d    = C_IDLE;
         end
         default: st_d = C_IDLE;
      endcase
      if (reset) begin
         fifo_push = 1'b0;
         cpu_ack   = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) st_q <= C_IDLE;
      else       st_q <= st_d;
   end

   // Loader holding register; load and drain are mutually exclusive since a
   // load needs it empty and a drain needs it full.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ld_full_q <= 1'b0;
         ld_addr_q <= '0;
         ld_data_q <= '0;
      end else if (ld_wr && !ld_full_q) begin
         ld_full_q <= 1'b1;
         ld_addr_q <= ld_addr;
         ld_data_q <= ld_din;
      end else if (slot == SLOT_LD) begin
         ld_full_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) vid_valid_q <= 1'b0;
      else       vid_valid_q <= vid_req;
   end

   assign ld_ready  = ~ld_full_q | reset;
   assign vid_valid = vid_valid_q;
   assign vid_dout  = vid_valid_q ? ram_dout : '0;
   assign cpu_dout  = (st_q == C_RDATA && !reset) ? ram_dout : '0;

`ifdef VRAM_ARBITER_STATS_EN
   logic [15:0] stall_cnt_q, full_cnt_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         stall_cnt_q <= '0;
         full_cnt_q  <= '0;
      end else begin
         if (cpu_req && !cpu_ack && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
         if (fifo_full && full_cnt_q != 16'hFFFF)            full_cnt_q  <= full_cnt_q + 16'd1;
      end
   end

   assign stat_cpu_stall = stall_cnt_q;
   assign stat_fifo_full = full_cnt_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

   localparam int unsigned AW    = 15;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_dout;
   logic          vid_valid;
   logic          ld_wr;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_din;
   logic          ld_ready;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic [DW-1:0] cpu_dout;
   logic          cpu_ack;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;
`ifdef VRAM_ARBITER_STATS_EN
   logic [15:0]   stat_cpu_stall;
   logic [15:0]   stat_fifo_full;
`endif

   always #5 clk_sys = ~clk_sys;

   vram_arbiter #(
      .AW(AW),
      .DW(DW),
      .WFIFO_DEPTH(DEPTH)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_dout  (vid_dout),
      .vid_valid (vid_valid),
      .ld_wr     (ld_wr),
      .ld_addr   (ld_addr),
      .ld_din    (ld_din),
      .ld_ready  (ld_ready),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .cpu_dout  (cpu_dout),
      .cpu_ack   (cpu_ack),
`ifdef VRAM_ARBITER_STATS_EN
      .stat_cpu_stall (stat_cpu_stall),
      .stat_fifo_full (stat_fifo_full),
`endif
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout)
   );

   // Single-port RAM with registered, read-before-write output.
   bit [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk_sys) begin
      if (ram_we) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
   end

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: transaction queues plus the memory contents it implies.
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;
   typedef struct {
      bit            we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cpu_txn_t;

   wr_t           m_q[$];        // posted writes not yet in RAM
   bit            m_ld_full;
   wr_t           m_ld;
   bit            m_ack_now;     // ack expected in the current cycle
   bit            m_rd_wait;     // read accepted, waiting for its slot
   bit            m_rd_now;      // current ack carries read data
   logic [DW-1:0] m_rd_data;
   bit            m_vid_prev;
   logic [DW-1:0] m_vid_data;
   bit [DW-1:0]   ref_mem [0:(1<<AW)-1];
   int unsigned   m_stall, m_ffull;

   cpu_txn_t cpu_txq[$];
   cpu_txn_t cur;
   bit       cpu_active;
   bit       ack_seen;
   wr_t      ld_txq[$];

   task automatic model_clear();
      m_q.delete();
      m_ld_full  = 0;
      m_ack_now  = 0;
      m_rd_wait  = 0;
      m_rd_now   = 0;
      m_vid_prev = 0;
      m_stall    = 0;
      m_ffull    = 0;
   endtask

   task automatic step(input bit rst, input bit v, input logic [AW-1:0] va);
      bit            exp_we, rd_won, idle, n_ack, ld_full_before;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_din;
      int            q_before;
      wr_t           ld_in;
      @(negedge clk_sys);
      reset    = rst;
      vid_req  = v;
      vid_addr = va;
      if (rst) begin
         cpu_txq.delete();
         ld_txq.delete();
         cpu_active = 0;
      end else begin
         if (cpu_active && ack_seen) cpu_active = 0;
         if (!cpu_active && cpu_txq.size() > 0) begin
            cur        = cpu_txq.pop_front();
            cpu_active = 1;
         end
      end
      cpu_req  = cpu_active;
      cpu_we   = cur.we;
      cpu_addr = cur.a;
      cpu_din  = cur.d;
      ld_wr    = 0;
      ld_addr  = '0;
      ld_din   = '0;
      if (!rst) begin
         if (!m_ld_full && ld_txq.size() > 0) begin
            ld_in   = ld_txq.pop_front();
            ld_wr   = 1;
            ld_addr = ld_in.a;
            ld_din  = ld_in.d;
         end else if (m_ld_full && $urandom_range(3) == 0) begin
            // strobe while busy must be dropped
            ld_wr   = 1;
            ld_addr = AW'(15'h3FFF);
            ld_din  = 8'hEE;
         end
      end
      #1;
      if (rst) begin
         check_eq("rst_ram_we", ram_we, 0);
         check_eq("rst_ram_addr", ram_addr, 0);
         check_eq("rst_ram_din", ram_din, 0);
         check_eq("rst_cpu_ack", cpu_ack, 0);
         check_eq("rst_ld_ready", ld_ready, 1);
         ack_seen = 0;
         model_clear();
      end else begin
         rd_won   = 0;
         exp_we   = 0;
         exp_addr = va;
         exp_din  = '0;
         if (v) begin
            exp_we = 0;
         end else if (m_ld_full) begin
            exp_we = 1; exp_addr = m_ld.a; exp_din = m_ld.d;
         end else if (m_q.size() > 0) begin
            exp_we = 1; exp_addr = m_q[0].a; exp_din = m_q[0].d;
         end else if (m_rd_wait) begin
            exp_addr = cpu_addr; rd_won = 1;
         end
         check_eq("vid_valid", vid_valid, m_vid_prev);
         if (m_vid_prev) check_eq("vid_dout", vid_dout, m_vid_data);
         check_eq("cpu_ack", cpu_ack, m_ack_now);
         if (m_rd_now) check_eq("cpu_dout", cpu_dout, m_rd_data);
         check_eq("ld_ready", ld_ready, !m_ld_full);
         check_eq("ram_we", ram_we, exp_we);
         check_eq("ram_addr", ram_addr, exp_addr);
         if (exp_we) check_eq("ram_din", ram_din, exp_din);
`ifdef VRAM_ARBITER_STATS_EN
         check_eq("stat_cpu_stall", stat_cpu_stall, m_stall);
         check_eq("stat_fifo_full", stat_fifo_full, m_ffull);
`endif
         ack_seen = cpu_ack;

         idle           = !m_ack_now && !m_rd_wait;
         q_before       = m_q.size();
         ld_full_before = m_ld_full;
         if (cpu_req && !m_ack_now && m_stall < 32'hFFFF) m_stall++;
         if (q_before == DEPTH && m_ffull < 32'hFFFF) m_ffull++;
         m_vid_prev = v;
         m_vid_data = ref_mem[va];
         m_rd_now   = rd_won;
         n_ack      = rd_won;
         if (rd_won) begin
            m_rd_data = ref_mem[cpu_addr];
            m_rd_wait = 0;
         end
         if (exp_we) begin
            ref_mem[exp_addr] = exp_din;
            if (ld_full_before) m_ld_full = 0;
            else                void'(m_q.pop_front());
         end
         if (idle && cpu_req) begin
            if (!cpu_we) begin
               m_rd_wait = 1;
            end else if (q_before < DEPTH) begin
               m_q.push_back('{cpu_addr, cpu_din});
               n_ack = 1;
            end
         end
         if (ld_wr && !ld_full_before) begin
            m_ld_full = 1;
            m_ld      = '{ld_addr, ld_din};
         end
         m_ack_now = n_ack;
      end
      @(posedge clk_sys);
   endtask

   initial begin
      reset = 1; vid_req = 0; vid_addr = '0; ld_wr = 0; ld_addr = '0; ld_din = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
      cur = '{0, '0, '0};
      cpu_active = 0; ack_seen = 0;
      model_clear();

      for (int i = 0; i < 3; i++) step(1, 0, '0);
      #1;
      check_eq("rst_vid_valid", vid_valid, 0);
      check_eq("rst_vid_dout", vid_dout, 0);
      check_eq("rst_cpu_dout", cpu_dout, 0);
      check_eq("rst_cpu_ack2", cpu_ack, 0);
      check_eq("rst_ld_ready2", ld_ready, 1);

      // Posted write under video pressure
      cpu_txq.push_back('{1, 15'h4000, 8'hA5});
      for (int i = 0; i < 3; i++) step(0, 1, AW'($urandom));
      for (int i = 0; i < 4; i++) step(0, 0, AW'($urandom));

      // Five writes against continuous video: FIFO fills, fifth waits
      for (int i = 0; i < 5; i++) cpu_txq.push_back('{1, AW'(15'h4100 + i), DW'(8'h50 + i)});
      for (int i = 0; i < 14; i++) step(0, 1, AW'($urandom));
      for (int i = 0; i < 10; i++) step(0, 0, AW'($urandom));

      // Read-after-write ordering
      cpu_txq.push_back('{1, 15'h5800, 8'h3C});
      cpu_txq.push_back('{0, 15'h5800, 8'h00});
      for (int i = 0; i < 8; i++) step(0, 0, AW'($urandom));

      // Alternate video slots with a 16-byte loader stream
      for (int i = 0; i < 16; i++) ld_txq.push_back('{AW'(15'h0100 + i), DW'(i * 7 + 1)});
      for (int i = 0; i < 40; i++) step(0, (i % 2) == 0, AW'(15'h0100 + i));

      // Reset with writes queued and a read waiting
      for (int i = 0; i < 3; i++) cpu_txq.push_back('{1, 15'h4000, DW'(8'h11 * (i + 1))});
      cpu_txq.push_back('{0, 15'h4100, 8'h00});
      for (int i = 0; i < 9; i++) step(0, 1, AW'($urandom));
      for (int i = 0; i < 2; i++) step(1, 0, '0);
      for (int i = 0; i < 4; i++) step(0, 0, AW'($urandom));
      cpu_txq.push_back('{0, 15'h4000, 8'h00});
      for (int i = 0; i < 6; i++) step(0, 0, AW'($urandom));

`ifdef VRAM_ARBITER_STATS_EN
      step(1, 0, '0);
      cpu_txq.push_back('{0, 15'h4000, 8'h00});
      for (int i = 0; i < 10; i++) step(0, 1, AW'($urandom));
      #1;
      check_eq("stall10", stat_cpu_stall, 10);
      for (int i = 0; i < 4; i++) step(0, 0, AW'($urandom));
      step(1, 0, '0);
      #1;
      check_eq("stall_rst", stat_cpu_stall, 0);
      check_eq("ffull_rst", stat_fifo_full, 0);
`endif

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         if (ld_txq.size() < 2 && $urandom_range(7) == 0)
            ld_txq.push_back('{AW'($urandom_range(16'h3FFE)), DW'($urandom)});
         if (!cpu_active && cpu_txq.size() == 0 && $urandom_range(2) == 0)
            cpu_txq.push_back('{bit'($urandom_range(1)), AW'(15'h4000 + $urandom_range(31)),
                                DW'($urandom)});
         step(0, $urandom_range(4) < 3, AW'($urandom));
      end
      for (int i = 0; i < 20; i++) step(0, 0, AW'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Time-shares the single-port video RAM between three requesters.
- Video fetch unit: absolute priority, fixed 1-cycle read latency.
- Snapshot/loader write port.
- CPU port: posted writes and blocking reads.
Sits between the video controller, the CPU memory decoder and the VRAM macro, all in the clk_sys domain. Makes CPU-side VRAM traffic invisible to display timing.

Parameters:
AW, 15, VRAM address width
DW, 8, data width
WFIFO_DEPTH, 4, CPU posted-write FIFO entries (power of two, >=2)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
vid_req  in  1  video read request, single-cycle, must be served the same cycle
vid_addr  in  AW  video read address
vid_dout  out  DW  video read data
vid_valid  out  1  vid_dout valid, exactly 1 cycle after vid_req
ld_wr  in  1  loader write strobe, accepted only when ld_ready=1
ld_addr  in  AW  loader address
ld_din  in  DW  loader data
ld_ready  out  1  loader holding register empty
cpu_req  in  1  CPU request, level, held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  AW  CPU address
cpu_din  in  DW  CPU write data
cpu_dout  out  DW  CPU read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_we  out  1  RAM write enable
ram_dout  in  DW  RAM read data, registered, 1-cycle latency

Behaviour:
- Exactly one RAM operation per clk_sys cycle.
- Slot priority, evaluated combinationally:
  1. vid_req
  2. loader holding register full
  3. write FIFO non-empty (drain head)
  4. CPU read pending AND FIFO empty AND no read already in flight
- Outputs ram_addr/ram_din/ram_we are combinational from the winning slot. Idle slot: ram_we=0, ram_addr=vid_addr.
- Video: vid_valid = registered vid_req; vid_dout = ram_dout on that cycle.
- Loader: ld_wr with ld_ready=1 loads the holding register; ld_ready drops the next cycle and rises the cycle after the RAM write slot. ld_wr while ld_ready=0 is ignored.
- CPU write:
  - Accepted when cpu_req & cpu_we & FIFO not full & no ack pulse this cycle.
  - cpu_ack pulses the cycle after acceptance.
  - If the FIFO is full, the request waits with no ack.
- CPU read:
  - Issued only once the FIFO is empty (read-after-write ordering guaranteed).
  - cpu_ack and cpu_dout = ram_dout one cycle after the read slot.
  - A read that loses its slot to video/loader retries the next cycle.
- CPU FSM states:
  - C_IDLE -> (write accepted) C_WACK -> C_IDLE
  - C_IDLE -> (read pending) C_RWAIT -> (slot won) C_RDATA -> (ack) C_IDLE
  - cpu_req is sampled again only from C_IDLE, so a held request is never double-served.
- FIFO:
  - Pointers have log2(WFIFO_DEPTH)+1 bits; full/empty are derived from MSB compare; wrap-around is natural.
  - Simultaneous push and pop when full is not allowed (push blocked); when empty, push then pop next cycle.
- Simultaneous vid_req and loader/FIFO/read: video wins; others stall. No starvation bound is provided (the display guarantees idle slots in border/blank).
- Reset: FIFO flushed (pending posted writes dropped), holding register cleared, FSM to C_IDLE.
  - Output reset values: vid_valid=0, vid_dout=0, ld_ready=1, cpu_ack=0, cpu_dout=0, ram_we=0, ram_addr=0, ram_din=0.
  - Reset mid-read: no ack issued.

Optional Feature:
VRAM_ARBITER_STATS_EN
- Defined: adds outputs stat_cpu_stall[15:0] and stat_fifo_full[15:0].
  - stat_cpu_stall counts cycles with cpu_req=1 and FSM not acking.
  - stat_fifo_full counts cycles with the FIFO full.
  - Both are saturating at 16'hFFFF and cleared by reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package vram_arb_pkg holds:
  - typedef slot_e {SLOT_IDLE, SLOT_VID, SLOT_LD, SLOT_WR, SLOT_RD}
  - typedef cpu_st_e {C_IDLE, C_WACK, C_RWAIT, C_RDATA}
  - struct wr_entry_t {addr, data}
- One sub-module: vram_wfifo (parameterised synchronous FIFO with push/pop/full/empty/head).

Test Plan:
- CPU write 0x4000<=0xA5 with vid_req held high 3 cycles -> cpu_ack 1 cycle after accept; ram_we with 0x4000/0xA5 on the first cycle vid_req=0.
- Five back-to-back CPU writes, vid_req=1 continuously -> 4 acked, 5th stalls with no ack until vid_req drops; all five reach RAM in order.
- Write 0x5800<=0x3C then immediate read 0x5800 -> read slot only after FIFO drains; cpu_dout=0x3C.
- vid_req on alternate cycles plus loader stream of 16 bytes -> vid_valid every time exactly 1 cycle later; all loader bytes written in order; ld_ready deasserts/asserts per the rules above.
- Reset asserted while 3 writes are queued and a read is in C_RWAIT -> no further ram_we, no cpu_ack; ld_ready=1; FIFO empty after reset.
- With VRAM_ARBITER_STATS_EN: 10 stalled cycles -> stat_cpu_stall=10; reset -> 0.
